// File: rtl/rsa_pkg.sv
// Shared constants and the driver state encoding for the RSA host driver.
package rsa_pkg;
  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;
  localparam int LOAD_WORDS = 12;
  localparam int RES_WORDS  = 4;

  typedef enum logic [2:0] {IDLE, KICK, LOAD, WAIT, CAPTURE, DONE} state_t;
endpackage

// File: rtl/rsa_word_collector.sv
// Assembles the core's result words into one wide result.
// start loads word 0 and zeroes the rest; capture writes word idx.
module rsa_word_collector #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       capture,
  input  logic [$clog2(WORDS)-1:0]   idx,
  input  logic [WORD_W-1:0]          word,
  output logic [WORDS*WORD_W-1:0]    res
);
  logic [WORDS-1:0][WORD_W-1:0] words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words <= '0;
    end else if (clear) begin
      words <= '0;
    end else if (start) begin
      words    <= '0;
      words[0] <= word;
    end else if (capture) begin
      words[idx] <= word;
    end
  end

  assign res = words;
endmodule

// File: rtl/rsa_host_driver.sv
// Host-side initiator for the 128-bit RSA core word interface: one job in flight.
// Optional WAIT watchdog is built when RSA_DRV_TIMEOUT_EN is defined.
module rsa_host_driver #(
  parameter int KEY_W   = 128,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_msg,
  input  logic [KEY_W-1:0]  in_exp,
  input  logic [KEY_W-1:0]  in_mod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEY_W-1:0]  out_res,
  output logic              out_err,
  output logic              core_enable,
  output logic              core_write,
  output logic [WORD_W-1:0] core_data,
  input  logic [WORD_W-1:0] core_out,
  input  logic              core_flag
);
  import rsa_pkg::*;

  state_t               state, state_nx;
  logic [3*KEY_W-1:0]   buf_q;
  logic [3:0]           cnt;
  logic                 col_start, col_cap, col_clr, timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      buf_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE:    if (in_valid) begin
                   buf_q <= {in_mod, in_exp, in_msg};
                   cnt   <= '0;
                 end
        LOAD:    begin
                   buf_q <= buf_q >> WORD_W;
                   cnt   <= cnt + 4'd1;
                 end
        WAIT:    if (core_flag) cnt <= 4'd1;
        CAPTURE: cnt <= cnt + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    core_enable = 1'b0;
    core_write  = 1'b0;
    core_data   = '0;
    col_start   = 1'b0;
    col_cap     = 1'b0;
    col_clr     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = KICK;
      end
      KICK: begin
        core_enable = 1'b1;
        state_nx    = LOAD;
      end
      LOAD: begin
        core_write = 1'b1;
        core_data  = buf_q[WORD_W-1:0];
        if (cnt == 4'(LOAD_WORDS-1)) state_nx = WAIT;
      end
      WAIT: begin
        if (core_flag) begin
          col_start = 1'b1;
          state_nx  = CAPTURE;
        end else if (timeout_hit) begin
          // aborted jobs report a zero result alongside out_err
          col_clr  = 1'b1;
          state_nx = DONE;
        end
      end
      CAPTURE: begin
        col_cap = 1'b1;
        if (cnt == 4'(RES_WORDS-1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef RSA_DRV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT+1);
  logic [WD_W-1:0] wd;
  logic            err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd <= (state == WAIT) ? wd + 1'b1 : '0;
      if (col_clr)                         err <= 1'b1;
      else if (state == DONE && out_ready) err <= 1'b0;
    end
  end

  // wd counts cycles already spent in WAIT, so DONE lands TIMEOUT cycles after entry
  assign timeout_hit = (wd == WD_W'(TIMEOUT-1));
  assign out_err     = err;
`else
  assign timeout_hit = 1'b0;
  assign out_err     = 1'b0;
`endif

  rsa_word_collector #(.WORD_W(WORD_W), .WORDS(RES_WORDS)) u_collector (
    .clk     (clk),
    .rst     (rst),
    .clear   (col_clr),
    .start   (col_start),
    .capture (col_cap),
    .idx     (cnt[1:0]),
    .word    (core_out),
    .res     (out_res)
  );
endmodule
